// File: rtl/count_pkg.sv
// Shared types and default parameters for the count_sched block.
package count_pkg;

  localparam int unsigned NReqDefault = 3;
  localparam int unsigned WDefault    = 8;
  localparam int unsigned LwDefault   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StDone
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request searching from last+1 modulo NREQ.
module rr_pick
  import count_pkg::*;
#(
  parameter int unsigned NREQ = NReqDefault,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   winner_o
);

  int unsigned cand;

  // Walk the ring once starting after the previous winner; first hit wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_i) + k) % NREQ;
      if (!valid_o && req_i[IW'(cand)]) begin
        valid_o  = 1'b1;
        winner_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler driving a shared saturating up/down counter in bursts.
module count_sched
  import count_pkg::*;
#(
  parameter int unsigned NREQ = NReqDefault,
  parameter int unsigned W    = WDefault,
  parameter int unsigned LW   = LwDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*LW-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic              sat,
  output logic [W-1:0]      q
);

  localparam int unsigned IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [W-1:0]    q_q, q_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            sat_q, sat_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [LW-1:0]   len_arr [NREQ];
  logic            at_bound;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .winner_o(pick_idx)
  );

  // Split the packed length bus into per-requester fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      len_arr[i] = len[i*LW +: LW];
    end
  end

  // Direction is carried by the state itself, so the bound depends on UP vs DOWN.
  always_comb begin
    at_bound = (state_q == StUp) ? (q_q == '1) : (q_q == '0);
  end

  // Next-state: arbitration in IDLE, one step per UP/DOWN cycle, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        sat_d = 1'b0;
        if (pick_valid) begin
          win_d  = pick_idx;
          last_d = pick_idx;
          rem_d  = len_arr[pick_idx];
          if (len_arr[pick_idx] == '0) begin
            state_d = StDone;
          end else begin
            state_d = dir[pick_idx] ? StUp : StDown;
            gnt_d   = NREQ'(1) << pick_idx;
          end
        end
      end
      StUp, StDown: begin
        if (!req[win_q]) begin
          // Abandon: no step, no done.
          state_d = StIdle;
          gnt_d   = '0;
          rem_d   = '0;
        end else if (rem_q == '0 || at_bound) begin
          state_d = StDone;
          gnt_d   = '0;
          sat_d   = at_bound;
        end else begin
          q_d   = (state_q == StUp) ? q_q + W'(1) : q_q - W'(1);
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d = StDone;
            gnt_d   = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        sat_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_q     <= '0;
      rem_q   <= '0;
      win_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sat_q   <= sat_d;
    end
  end

  assign gnt  = gnt_q;
  assign q    = q_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sat  = sat_q;

endmodule

// File: tb/tb_count_sched.sv
// Scoreboard bench for count_sched: model predicts each burst's outcome, monitor checks at done.
module tb_count_sched;

  localparam int unsigned NREQ = 3;
  localparam int unsigned W    = 8;
  localparam int unsigned LW   = 4;
  localparam int QMAX = (1 << W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req, dir, gnt;
  logic [NREQ*LW-1:0] len;
  logic               busy, done, sat;
  logic [W-1:0]       q;

  always #5 clk = ~clk;

  count_sched #(
    .NREQ(NREQ),
    .W   (W),
    .LW  (LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .dir  (dir),
    .len  (len),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .sat  (sat),
    .q    (q)
  );

  typedef struct {
    int win;
    int qv;
    int satv;
    int ngnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0, n_errors = 0;
  int done_seen = 0, gcnt = 0, gwin = -1;
  int q_m = 0, last_m = NREQ - 1;
  int dir_m[NREQ], len_m[NREQ];

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: tracks grant cycles and checks each completed burst against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      gcnt = 0;
    end else begin
      chk("sat_implies_done", int'(sat & ~done), 0);
      chk("gnt_implies_busy", int'((gnt != '0) && !busy), 0);
      if (gnt != '0) begin
        chk("gnt_onehot", int'($onehot(gnt)), 1);
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gwin = i;
        gcnt++;
      end
      if (done) begin
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("q_at_done", int'(q), mon_e.qv);
          chk("sat_at_done", int'(sat), mon_e.satv);
          chk("gnt_cycles", gcnt, mon_e.ngnt);
          if (mon_e.ngnt > 0) chk("winner", gwin, mon_e.win);
        end
        done_seen++;
        gcnt = 0;
      end
      if (!busy) gcnt = 0;
    end
  end

  // Reference arbitration: first requester after the previous winner.
  function automatic int pick(logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last_m + k) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Reference burst outcome: steps limited by distance to the bound; hitting it costs one cycle.
  task automatic predict(int w);
    exp_t e;
    int l, room, steps;
    l = len_m[w];
    e.win = w;
    e.satv = 0;
    if (l == 0) begin
      steps = 0;
      e.ngnt = 0;
    end else begin
      room = (dir_m[w] != 0) ? (QMAX - q_m) : q_m;
      if (l > room) begin
        steps = room;
        e.satv = 1;
        e.ngnt = room + 1;
      end else begin
        steps = l;
        e.ngnt = l;
      end
    end
    q_m = (dir_m[w] != 0) ? q_m + steps : q_m - steps;
    e.qv = q_m;
    exp_q.push_back(e);
    last_m = w;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      dir[i] = dir_m[i][0];
      len[i*LW +: LW] = len_m[i][LW-1:0];
    end
  endtask

  task automatic wait_dones(int target, int budget);
    int t;
    t = 0;
    while (done_seen < target && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("done_within_budget", int'(done_seen >= target), 1);
  endtask

  // Hold request vector r until nb bursts have completed, then release it in the DONE cycle.
  task automatic run(logic [NREQ-1:0] r, int nb);
    int target;
    @(negedge clk);
    apply_inputs();
    req = r;
    target = done_seen + nb;
    for (int b = 0; b < nb; b++) predict(pick(r));
    wait_dones(target, 40 * nb);
    req = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    dir = '0;
    len = '0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sat", int'(sat), 0);
    exp_q.delete();
    q_m = 0;
    last_m = NREQ - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, cnt, d0, target;
    for (int i = 0; i < NREQ; i++) begin
      dir_m[i] = 1;
      len_m[i] = 0;
    end
    rst_n = 1'b1;
    req = '0;
    dir = '0;
    len = '0;
    #2;
    do_reset();

    // Basic up burst; winner's dir/len changed mid-burst must be ignored.
    dir_m[0] = 1;
    len_m[0] = 3;
    @(negedge clk);
    apply_inputs();
    req = 3'b001;
    target = done_seen + 1;
    predict(pick(req));
    @(negedge clk);
    @(negedge clk);
    dir[0] = 1'b0;
    len[LW-1:0] = '1;
    wait_dones(target, 40);
    req = '0;

    // Preload toward 253 with requester 0, then saturate with requester 1.
    while (q_m < QMAX - 2) begin
      dir_m[0] = 1;
      len_m[0] = (QMAX - 2 - q_m > 15) ? 15 : QMAX - 2 - q_m;
      run(3'b001, 1);
    end
    dir_m[1] = 1;
    len_m[1] = 5;
    run(3'b010, 1);
    chk("sat_q_255", int'(q), QMAX);

    // Rotation from reset: grants 0,1,2,0.
    do_reset();
    dir_m[0] = 1; dir_m[1] = 0; dir_m[2] = 1;
    len_m[0] = 1; len_m[1] = 1; len_m[2] = 1;
    run(3'b111, 4);

    // Abandon: bring q to 10, then drop requester 2 after two down steps.
    dir_m[0] = 1;
    len_m[0] = 10 - q_m;
    run(3'b001, 1);
    dir_m[2] = 0;
    len_m[2] = 4;
    d0 = done_seen;
    @(negedge clk);
    apply_inputs();
    req = 3'b100;
    cnt = 0;
    t = 0;
    while (cnt < 3 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
      if (gnt[2]) cnt++;
    end
    chk("abandon_gnt_seen", cnt, 3);
    req = '0;
    @(negedge clk);
    #1;
    chk("abandon_busy", int'(busy), 0);
    chk("abandon_q", int'(q), 8);
    chk("abandon_gnt", int'(gnt), 0);
    repeat (3) @(negedge clk);
    chk("abandon_no_done", done_seen, d0);
    q_m = 8;
    last_m = 2;

    // Zero length: done one cycle after selection, no grant, q unchanged.
    dir_m[0] = 1;
    len_m[0] = 0;
    @(negedge clk);
    apply_inputs();
    req = 3'b001;
    target = done_seen + 1;
    predict(pick(req));
    @(negedge clk);
    #1;
    chk("zero_len_done", int'(done), 1);
    chk("zero_len_gnt", int'(gnt), 0);
    chk("zero_len_q", int'(q), 8);
    wait_dones(target, 10);
    req = '0;

    // Reset mid-burst: q and gnt clear immediately, no done afterwards.
    dir_m[0] = 1;
    len_m[0] = 6;
    @(negedge clk);
    apply_inputs();
    req = 3'b001;
    repeat (3) @(negedge clk);
    #1;
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    chk("midrst_q", int'(q), 0);
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    req = '0;
    exp_q.delete();
    q_m = 0;
    last_m = NREQ - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_seen, d0);

    // Randomised bursts against the model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        dir_m[i] = int'($urandom_range(0, 1));
        len_m[i] = int'($urandom_range(0, 15));
      end
      run(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(1, 4)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
